// File: rtl/jk_seq_pkg.sv
// Shared types for the JK counter sequencer: FSM states, excitation modes, J/K mapping.
// Latency: none (types and a pure combinational function).
// Backpressure: not applicable.
package jk_seq_pkg;

  // Widest register the excitation function supports; callers slice the low bits.
  localparam int JK_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_COUNT = 2'b01,
    MODE_LOAD  = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_t;

  typedef struct packed {
    logic [JK_MAX_W-1:0] j;
    logic [JK_MAX_W-1:0] k;
  } jk_vec_t;

  // Per-bit J/K excitation. Counting toggles bit i when all lower bits are
  // 1 (up) or all lower bits are 0 (down); bit 0 always toggles.
  function automatic jk_vec_t jk_excite(input mode_t mode,
                                        input logic [JK_MAX_W-1:0] q,
                                        input logic dir,
                                        input logic [JK_MAX_W-1:0] data);
    jk_vec_t r;
    logic    t_up;
    logic    t_dn;
    r    = '0;
    t_up = 1'b1;
    t_dn = 1'b1;
    for (int i = 0; i < JK_MAX_W; i++) begin
      case (mode)
        MODE_COUNT: begin
          r.j[i] = dir ? t_up : t_dn;
          r.k[i] = dir ? t_up : t_dn;
        end
        MODE_LOAD: begin
          r.j[i] = data[i];
          r.k[i] = ~data[i];
        end
        MODE_CLEAR: begin
          r.j[i] = 1'b0;
          r.k[i] = 1'b1;
        end
        default: begin
          r.j[i] = 1'b0;
          r.k[i] = 1'b0;
        end
      endcase
      t_up = t_up & q[i];
      t_dn = t_dn & ~q[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/jk_counter_sequencer_if.sv
// Control/status bundle between lab control logic and the JK counter sequencer.
// Latency: none (wiring only).
// Backpressure: none; LOAD is always accepted and acknowledged by LOAD_ACK.
interface jk_counter_sequencer_if #(parameter int WIDTH = 4);
  logic             input_ENA;
  logic             input_START;
  logic             input_STOP;
  logic             input_DIR;
  logic             input_ONESHOT;
  logic             input_LOAD;
  logic [WIDTH-1:0] input_DATA;
  logic             output_LOAD_ACK;
  logic [WIDTH-1:0] output_Q;
  logic [WIDTH-1:0] output_QL;
  logic             output_TC;
  logic             output_BUSY;
  logic [1:0]       output_STATE;

  modport master (
    output input_ENA, input_START, input_STOP, input_DIR, input_ONESHOT,
           input_LOAD, input_DATA,
    input  output_LOAD_ACK, output_Q, output_QL, output_TC, output_BUSY,
           output_STATE
  );

  modport slave (
    input  input_ENA, input_START, input_STOP, input_DIR, input_ONESHOT,
           input_LOAD, input_DATA,
    output output_LOAD_ACK, output_Q, output_QL, output_TC, output_BUSY,
           output_STATE
  );
endinterface

// File: rtl/jk_cell.sv
// Single JK flip-flop stage with complementary outputs.
// Latency: one clock from J/K to QH/QL.
// Backpressure: none.
module jk_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic qh,
  output logic ql
);

  // JK truth table: hold, reset, set, toggle; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qh <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   qh <= 1'b0;
        2'b10:   qh <= 1'b1;
        2'b11:   qh <= ~qh;
        default: qh <= qh;
      endcase
    end
  end

  assign ql = ~qh;

endmodule

// File: rtl/jk_counter_sequencer.sv
// Sequences a WIDTH-bit JK register: hold/count mod MOD_N/load/clear with run-stop-oneshot FSM.
// Latency: one clock from sampled controls to Q; TC and LOAD_ACK are registered (next cycle).
// Backpressure: none; LOAD accepted every cycle. JK_COUNTER_GRAY_EN presents Q in Gray code.
module jk_counter_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD_N = 10
) (
  input logic                   input_CLK,
  input logic                   input_RSTN,
  jk_counter_sequencer_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD_N - 1);
  localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MOD_N);

  state_t           state;
  state_t           state_nxt;
  mode_t            mode;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] ql;
  logic [WIDTH-1:0] mode_data;
  logic [WIDTH-1:0] load_val;
  logic             terminal;
  logic             tc;
  logic             tc_nxt;
  logic             ack;
  logic             ack_nxt;
  jk_vec_t          exc;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic             unused_exc_hi;

  // Out-of-range load values saturate to the top of the count range.
  assign load_val = ({1'b0, bus.input_DATA} >= MOD_W) ? MAX_VAL : bus.input_DATA;
  assign terminal = bus.input_DIR ? (q == MAX_VAL) : (q == '0);

  // Next state, excitation mode and registered pulses; priority LOAD > STOP > START > tick.
  always_comb begin
    case (state)
      ST_IDLE, ST_RUN, ST_DONE: state_nxt = state;
      default:                  state_nxt = ST_IDLE;
    endcase
    mode      = MODE_HOLD;
    mode_data = load_val;
    tc_nxt    = 1'b0;
    ack_nxt   = 1'b0;
    if (bus.input_LOAD) begin
      mode    = MODE_LOAD;
      ack_nxt = 1'b1;
    end else if (bus.input_STOP) begin
      state_nxt = ST_IDLE;
    end else if (bus.input_START) begin
      case (state)
        ST_IDLE: state_nxt = ST_RUN;
        ST_DONE: begin
          // Restart from the direction's starting point on the same edge.
          state_nxt = ST_RUN;
          if (bus.input_DIR) begin
            mode = MODE_CLEAR;
          end else begin
            mode      = MODE_LOAD;
            mode_data = MAX_VAL;
          end
        end
        ST_RUN:  state_nxt = ST_RUN;
        default: state_nxt = ST_IDLE;
      endcase
    end else if (state == ST_RUN && bus.input_ENA) begin
      if (terminal) begin
        tc_nxt = 1'b1;
        if (bus.input_ONESHOT) begin
          state_nxt = ST_DONE;
        end else if (bus.input_DIR) begin
          mode = MODE_CLEAR;
        end else begin
          mode      = MODE_LOAD;
          mode_data = MAX_VAL;
        end
      end else begin
        mode = MODE_COUNT;
      end
    end
  end

  assign exc   = jk_excite(mode, JK_MAX_W'(q), bus.input_DIR, JK_MAX_W'(mode_data));
  assign j_vec = exc.j[WIDTH-1:0];
  assign k_vec = exc.k[WIDTH-1:0];
  assign unused_exc_hi = ^{exc.j[JK_MAX_W-1:WIDTH], exc.k[JK_MAX_W-1:WIDTH]};

  // FSM state and one-cycle status pulses.
  always_ff @(posedge input_CLK) begin
    if (!input_RSTN) begin
      state <= ST_IDLE;
      tc    <= 1'b0;
      ack   <= 1'b0;
    end else begin
      state <= state_nxt;
      tc    <= tc_nxt;
      ack   <= ack_nxt;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_stage
    jk_cell u_cell (
      .clk   (input_CLK),
      .rst_n (input_RSTN),
      .j     (j_vec[g]),
      .k     (k_vec[g]),
      .qh    (q[g]),
      .ql    (ql[g])
    );
  end

`ifdef JK_COUNTER_GRAY_EN
  assign bus.output_Q = q ^ (q >> 1);
`else
  assign bus.output_Q = q;
`endif
  assign bus.output_QL       = ql;
  assign bus.output_TC       = tc;
  assign bus.output_LOAD_ACK = ack;
  assign bus.output_BUSY     = (state == ST_RUN);
  assign bus.output_STATE    = state;

endmodule

// File: tb/tb_jk_counter_sequencer.sv
// Self-checking bench for jk_counter_sequencer against an arithmetic reference model.
// Latency: checks one cycle after each sampling edge.
// Backpressure: not applicable.
module tb_jk_counter_sequencer;
  localparam int WIDTH = 4;
  localparam int MOD_N = 10;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  // Reference model: count as an integer, state as 0 idle / 1 run / 2 done.
  int m_cnt;
  int m_state;
  int m_tc;
  int m_ack;

  jk_counter_sequencer_if #(.WIDTH(WIDTH)) bus ();

  jk_counter_sequencer #(.WIDTH(WIDTH), .MOD_N(MOD_N)) dut (
    .input_CLK  (clk),
    .input_RSTN (rstn),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int shown_q(input int v);
`ifdef JK_COUNTER_GRAY_EN
    return v ^ (v >> 1);
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ena, input logic start, input logic stop, input logic dir,
                       input logic oneshot, input logic load, input int data);
    bus.input_ENA     = ena;
    bus.input_START   = start;
    bus.input_STOP    = stop;
    bus.input_DIR     = dir;
    bus.input_ONESHOT = oneshot;
    bus.input_LOAD    = load;
    bus.input_DATA    = WIDTH'(data);
  endtask

  // Apply the behavioural rules to the inputs sampled at this edge.
  task automatic model_edge();
    int d;
    m_tc  = 0;
    m_ack = 0;
    if (!rstn) begin
      m_cnt   = 0;
      m_state = 0;
    end else if (bus.input_LOAD) begin
      d     = int'(bus.input_DATA);
      m_cnt = (d >= MOD_N) ? MOD_N - 1 : d;
      m_ack = 1;
    end else if (bus.input_STOP) begin
      m_state = 0;
    end else if (bus.input_START) begin
      if (m_state == 2) m_cnt = bus.input_DIR ? 0 : MOD_N - 1;
      m_state = 1;
    end else if (m_state == 1 && bus.input_ENA) begin
      if (bus.input_DIR) begin
        if (m_cnt == MOD_N - 1) begin
          m_tc = 1;
          if (bus.input_ONESHOT) m_state = 2;
          else m_cnt = 0;
        end else m_cnt = m_cnt + 1;
      end else begin
        if (m_cnt == 0) begin
          m_tc = 1;
          if (bus.input_ONESHOT) m_state = 2;
          else m_cnt = MOD_N - 1;
        end else m_cnt = m_cnt - 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("q",        32'(bus.output_Q),        32'(shown_q(m_cnt)));
    check("ql",       32'(bus.output_QL),       32'((~m_cnt) & ((1 << WIDTH) - 1)));
    check("tc",       32'(bus.output_TC),       32'(m_tc));
    check("load_ack", 32'(bus.output_LOAD_ACK), 32'(m_ack));
    check("state",    32'(bus.output_STATE),    32'(m_state));
    check("busy",     32'(bus.output_BUSY),     32'(m_state == 1));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_cnt    = 0;
    m_state  = 0;
    m_tc     = 0;
    m_ack    = 0;
    rstn     = 1'b0;
    drive(0, 0, 0, 1, 0, 0, 0);
    step();
    check("reset_q",  32'(bus.output_Q),  32'(0));
    check("reset_ql", 32'(bus.output_QL), 32'(4'b1111));

    // Count up modulo 10 through a wrap.
    rstn = 1'b1;
    drive(1, 1, 0, 1, 0, 0, 0);
    step();
    drive(1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      check("up_seq_q", 32'(bus.output_Q),  32'(shown_q((i + 1) % 10)));
      check("up_seq_tc", 32'(bus.output_TC), 32'(i == 9));
    end
`ifdef JK_COUNTER_GRAY_EN
    check("gray_of_2", 32'(bus.output_Q), 32'(4'h3));
`endif
    drive(0, 0, 1, 1, 0, 0, 0);
    step();

    // One-shot down count from a loaded value.
    drive(0, 0, 0, 0, 1, 1, 3);
    step();
    check("ack_pulse", 32'(bus.output_LOAD_ACK), 32'(1));
    drive(0, 1, 0, 0, 1, 0, 0);
    step();
    check("ack_clear", 32'(bus.output_LOAD_ACK), 32'(0));
    drive(1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step();
    check("oneshot_done", 32'(bus.output_STATE), 32'(2'b10));
    check("oneshot_q",    32'(bus.output_Q),     32'(0));

    // Saturating load, then load beats a terminal tick.
    drive(0, 0, 1, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 0, 1, 15);
    step();
    check("load_sat", 32'(bus.output_Q), 32'(shown_q(9)));
    drive(0, 1, 0, 1, 0, 0, 0);
    step();
    drive(1, 0, 0, 1, 0, 1, 4);
    step();
    check("load_on_tc_q",  32'(bus.output_Q),  32'(shown_q(4)));
    check("load_on_tc_tc", 32'(bus.output_TC), 32'(0));

    // ENA gating, then STOP beats START.
    drive(1, 0, 0, 1, 0, 0, 0);
    step();
    step();
    step();
    drive(0, 0, 0, 1, 0, 0, 0);
    step();
    check("ena_hold", 32'(bus.output_Q), 32'(shown_q(7)));
    drive(1, 0, 0, 1, 0, 0, 0);
    step();
    drive(1, 1, 1, 1, 0, 0, 0);
    step();
    check("stop_wins_state", 32'(bus.output_STATE), 32'(0));
    check("stop_wins_q",     32'(bus.output_Q),     32'(shown_q(8)));

    // Reset mid-count.
    drive(1, 1, 0, 1, 0, 0, 0);
    step();
    drive(1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step();
    check("pre_reset_q", 32'(bus.output_Q), 32'(shown_q(5)));
    rstn = 1'b0;
    step();
    check("midrst_q",  32'(bus.output_Q),  32'(0));
    check("midrst_ql", 32'(bus.output_QL), 32'(4'b1111));
    rstn = 1'b1;

    // Randomised traffic against the model.
    begin
      logic r_dir;
      logic r_os;
      r_dir = 1'b1;
      r_os  = 1'b0;
      for (int n = 0; n < 600; n++) begin
        if ($urandom_range(0, 19) == 0) r_dir = ~r_dir;
        if ($urandom_range(0, 39) == 0) r_os  = ~r_os;
        rstn = ($urandom_range(0, 79) != 0);
        drive($urandom_range(0, 3) != 0,
              (m_state != 1) && ($urandom_range(0, 3) == 0),
              $urandom_range(0, 24) == 0,
              r_dir, r_os,
              $urandom_range(0, 14) == 0,
              int'($urandom_range(0, 15)));
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
